// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter for the register-file write port with mult/div pending scoreboard
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [NREG-1:0]   wr_sel,
  output logic [NREG-1:0]   pending
);
  logic              last_grant;
  logic              grant;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;
  logic [NREG-1:0]   pending_next;
  // Round-robin grant: on conflict the requester that did not win last time goes first
  always_comb begin
    req0_ready = req0_valid & (~req1_valid | last_grant);
    req1_ready = req1_valid & (~req0_valid | ~last_grant);
    grant      = req0_ready | req1_ready;
    grant_addr = req1_ready ? req1_addr : req0_addr;
    grant_data = req1_ready ? req1_data : req0_data;
  end
  // Scoreboard update: completion clears, issue sets afterwards so a same-register issue wins
  always_comb begin
    pending_next = pending;
    if (req1_ready) pending_next[req1_addr] = 1'b0;
    if (iss_valid && iss_addr != '0) pending_next[iss_addr] = 1'b1;
  end
  // Registered write port, grant history and scoreboard
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_sel     <= '0;
      pending    <= '0;
      last_grant <= 1'b1;
    end else begin
      if (grant) begin
        wr_addr    <= grant_addr;
        wr_data    <= grant_data;
        last_grant <= req1_ready;
      end
      wr_en   <= grant && grant_addr != '0;
      wr_sel  <= (grant && grant_addr != '0) ? NREG'(1) << grant_addr : '0;
      pending <= pending_next;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized check of the write-port arbiter against a behavioural model
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N = 32;
  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_data = '0;
  logic          req1_ready;
  logic          iss_valid = 1'b0;
  logic [AW-1:0] iss_addr = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [N-1:0]  wr_sel;
  logic [N-1:0]  pending;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREG(N)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_sel(wr_sel), .pending(pending)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int gnt;
  int order[4];
  logic [N-1:0] snap;

  bit            m_lg;
  bit            m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [N-1:0]  m_sel;
  bit            m_pend[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] pend_vec();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    m_lg = 1'b1;
    m_en = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_sel = '0;
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
  endtask

  task automatic check_outputs();
    chk("wr_en", wr_en, m_en);
    chk("wr_addr", wr_addr, m_addr);
    chk("wr_data", wr_data, m_data);
    chk("wr_sel", wr_sel, m_sel);
    chk("pending", pending, pend_vec());
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    iss_valid = 1'b0;
  endtask

  task automatic step();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = '0;
    d = '0;
    #1;
    if (req0_valid && req1_valid) gnt = m_lg ? 0 : 1;
    else if (req0_valid) gnt = 0;
    else if (req1_valid) gnt = 1;
    else gnt = -1;
    chk("req0_ready", req0_ready, gnt == 0);
    chk("req1_ready", req1_ready, gnt == 1);
    @(posedge clock);
    #1;
    if (gnt >= 0) begin
      a = (gnt == 1) ? req1_addr : req0_addr;
      d = (gnt == 1) ? req1_data : req0_data;
      m_addr = a;
      m_data = d;
      m_lg = (gnt == 1);
    end
    m_en = (gnt >= 0) && (a != 0);
    m_sel = '0;
    if (m_en) m_sel[a] = 1'b1;
    if (gnt == 1) m_pend[req1_addr] = 1'b0;
    if (iss_valid && iss_addr != 0) m_pend[iss_addr] = 1'b1;
    check_outputs();
  endtask

  task automatic do_reset();
    idle();
    @(posedge clock);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check_outputs();
    chk("reset_pending_lit", pending, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    // single ALU write
    req0_valid = 1'b1; req0_addr = 5; req0_data = 32'hDEADBEEF;
    step();
    chk("alu_grant_lit", gnt, 0);
    chk("alu_sel_lit", wr_sel, 32'h0000_0020);
    chk("alu_data_lit", wr_data, 32'hDEADBEEF);
    idle();
    step();
    chk("idle_hold_addr_lit", wr_addr, 5);
    // conflict round-robin from reset
    do_reset();
    req0_valid = 1'b1; req0_addr = 3; req0_data = 32'h3333;
    req1_valid = 1'b1; req1_addr = 9; req1_data = 32'h9999;
    for (int i = 0; i < 4; i++) begin
      step();
      order[i] = gnt;
      chk("rr_addr_lit", wr_addr, (i % 2 == 0) ? 3 : 9);
    end
    chk("rr_order_lit", {order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}, 8'b00_01_00_01);
    idle();
    // register 0 from mult/div
    req1_valid = 1'b1; req1_addr = 0; req1_data = 32'h1234;
    step();
    chk("r0_grant_lit", gnt, 1);
    chk("r0_en_lit", wr_en, 0);
    chk("r0_sel_lit", wr_sel, 0);
    idle();
    // scoreboard set and clear
    iss_valid = 1'b1; iss_addr = 12;
    step();
    chk("sb_set_lit", pending, 32'h0000_1000);
    idle();
    step();
    step();
    req1_valid = 1'b1; req1_addr = 12; req1_data = 32'hC0DE;
    step();
    chk("sb_clear_lit", pending, 32'h0);
    idle();
    // same-cycle set/clear and issue to r0
    iss_valid = 1'b1; iss_addr = 7;
    step();
    req1_valid = 1'b1; req1_addr = 7; req1_data = 32'h7777;
    step();
    chk("sb_setwins_lit", pending[7], 1);
    idle();
    iss_valid = 1'b1; iss_addr = 0;
    snap = pending;
    step();
    chk("sb_iss0_lit", pending, snap);
    // asynchronous reset while a write is on the port
    idle();
    req0_valid = 1'b1; req0_addr = 17; req0_data = 32'hABCD;
    iss_valid = 1'b1; iss_addr = 20;
    step();
    chk("pre_reset_en_lit", wr_en, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_wr_en", wr_en, 0);
    chk("async_wr_sel", wr_sel, 0);
    chk("async_pending", pending, 0);
    model_reset();
    idle();
    @(negedge clock);
    reset_n = 1'b1;
    // randomized traffic with hold-until-accepted requesters
    for (int i = 0; i < 3000; i++) begin
      if (!req0_valid || gnt == 0 || i == 0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_addr = AW'($urandom);
        req0_data = $urandom;
      end
      if (!req1_valid || gnt == 1 || i == 0) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_addr = AW'($urandom);
        req1_data = $urandom;
      end
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_addr = AW'($urandom);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: requester 0 is the ALU pipeline writeback; requester 1 is the multi-cycle mult/div unit.
- Issues a registered write enable, address, data and one-hot register select. The one-hot select matches the 5-to-32 write decoder's output encoding, so it drives the per-register enables directly.
- Keeps a pending-write scoreboard for long-latency mult/div destinations, which the hazard/stall logic reads.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width
NREG, 32, number of registers (2**ADDR_W), width of select and pending vectors

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req0_valid  in  1  ALU writeback request
req0_addr  in  ADDR_W  ALU destination register
req0_data  in  DATA_W  ALU result
req0_ready  out  1  ALU request accepted this cycle
req1_valid  in  1  mult/div writeback request
req1_addr  in  ADDR_W  mult/div destination register
req1_data  in  DATA_W  mult/div result
req1_ready  out  1  mult/div request accepted this cycle
iss_valid  in  1  mult/div operation issued this cycle
iss_addr  in  ADDR_W  destination register of issued mult/div op
wr_en  out  1  register-file write enable (registered)
wr_addr  out  ADDR_W  write address (registered)
wr_data  out  DATA_W  write data (registered)
wr_sel  out  NREG  one-hot register select (registered); all zero when wr_en=0
pending  out  NREG  scoreboard: bit r=1 means a mult/div write to r is outstanding

Behaviour:
- Reset (reset_n low, asynchronous): wr_en=0, wr_addr=0, wr_data=0, wr_sel=0, pending=0, last_grant=1. With last_grant=1, requester 0 wins the first conflict.
- Handshake:
  - reqN_ready is combinational from both valids and last_grant.
  - A transfer happens when valid and ready are both 1.
  - A requester holds valid, addr and data stable until ready. It may not drop valid before it is accepted.
  - ready is never 1 when the matching valid is 0.
- Arbitration, at most one grant per cycle:
  - Only one valid: that requester is granted.
  - Both valid: the requester that is not last_grant is granted (round-robin).
  - last_grant updates to the granted index only on a grant. It holds on idle cycles.
- Write port, one-cycle latency:
  - On the clock edge after a grant: wr_addr and wr_data take the granted request, and wr_en=1 if addr!=0.
  - wr_sel has bit[addr] set, and only when wr_en=1.
  - On a cycle with no grant, wr_en=0 and wr_sel=0. wr_addr and wr_data hold their previous values.
  - Writes to register 0 are accepted (ready=1) but produce wr_en=0 and wr_sel=0.
- Scoreboard:
  - iss_valid with iss_addr!=0 sets pending[iss_addr] on the next edge.
  - An accepted req1 transfer clears pending[req1_addr] on the next edge.
  - If issue and clear hit the same register in the same cycle, set wins: the new op is outstanding.
  - Issue to register 0 is ignored; pending[0] is always 0.
  - req0 transfers do not affect pending.
  - Issue to an already-pending register leaves the bit at 1 (no count).
- Reset asserted mid-operation: all state is cleared immediately and any write not yet presented on the write port is lost. After reset release, requesters re-present their requests.
- No combinational path from the inputs to any wr_* output. pending is a direct register output.

Test Plan:
- Reset: assert reset_n=0 mid-stream while wr_en=1 -> wr_en=0, wr_sel=0 and pending=0 immediately, without a clock edge.
- Single ALU write: req0 {addr=5, data=0xDEADBEEF} alone -> req0_ready=1 the same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, wr_sel=0x00000020.
- Conflict round-robin: both valid for 4 cycles, each re-presenting after acceptance, starting after reset -> grant order 0,1,0,1; wr_addr alternates between the two requesters' addrs with no gaps.
- Register 0: req1 {addr=0, data=0x1234} -> req1_ready=1; next cycle wr_en=0 and wr_sel=0.
- Scoreboard: iss_valid addr=12 -> pending=0x00001000. Three cycles later, req1 addr=12 accepted -> pending=0 the cycle after.
- Same-cycle set/clear: req1 accepted for addr=7 while iss_valid addr=7 -> pending[7] stays 1. Issue with addr=0 -> pending stays unchanged.
